// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war match logic.
package tow_pkg;

  typedef enum logic [1:0] {
    START,
    PLAY,
    PAUSE,
    DONE
  } match_state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam int unsigned BCD_MAX = 9;

endpackage

// File: rtl/pause_timer.sv
// Loadable down-counter with a done flag.
// The count parks at zero until it is reloaded.
module pause_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/match_controller.sv
// First-to-WIN_SCORE match controller: scores round wins, sequences the
// playfield round reset/pause and declares the match winner.
module match_controller
  import tow_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned PAUSE_CYCLES = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_win,
  input  logic       right_win,
  input  logic       new_match,
  output logic       round_reset,
  output logic       play_en,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam int unsigned CNT_W      = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [3:0]       WIN_PTS    = 4'(WIN_SCORE);

  match_state_t state_q;
  logic [3:0]   score_l_q, score_r_q;
  logic [1:0]   winner_q;
  logic         match_over_q;
  logic         timer_load, timer_en, timer_done;

  // Loading on every scored or drawn round is harmless when the round ends the match.
  assign timer_load = (state_q == PLAY) && (left_win || right_win) && !new_match;
  assign timer_en   = (state_q == PAUSE);

  pause_timer #(
    .WIDTH(CNT_W)
  ) u_pause_timer (
    .clk  (clk),
    .reset(reset),
    .load (timer_load),
    .value(PAUSE_LOAD),
    .en   (timer_en),
    .done (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= START;
      score_l_q    <= '0;
      score_r_q    <= '0;
      winner_q     <= WIN_NONE;
      match_over_q <= 1'b0;
    end else if (new_match) begin
      state_q      <= START;
      score_l_q    <= '0;
      score_r_q    <= '0;
      winner_q     <= WIN_NONE;
      match_over_q <= 1'b0;
    end else begin
      unique case (state_q)
        START: state_q <= PLAY;
        PLAY: begin
          if (left_win && right_win) begin
            state_q <= PAUSE;
          end else if (left_win) begin
            if (score_l_q < WIN_PTS) score_l_q <= score_l_q + 4'd1;
            if (score_l_q + 4'd1 >= WIN_PTS) begin
              state_q      <= DONE;
              match_over_q <= 1'b1;
              winner_q     <= WIN_LEFT;
            end else begin
              state_q <= PAUSE;
            end
          end else if (right_win) begin
            if (score_r_q < WIN_PTS) score_r_q <= score_r_q + 4'd1;
            if (score_r_q + 4'd1 >= WIN_PTS) begin
              state_q      <= DONE;
              match_over_q <= 1'b1;
              winner_q     <= WIN_RIGHT;
            end else begin
              state_q <= PAUSE;
            end
          end
        end
        PAUSE: if (timer_done) state_q <= PLAY;
        DONE:  state_q <= DONE;
        default: state_q <= START;
      endcase
    end
  end

  assign round_reset = (state_q != PLAY);
  assign play_en     = (state_q == PLAY);
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign match_over  = match_over_q;
  assign winner      = winner_q;

endmodule
